// File: rtl/run_host_if.sv
// Host-side bundle for run_host_ctrl.
// Groups load, memory, run and dump signals.
interface run_host_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        go;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        start;
  logic        done;
  logic        run_active;
  logic        dump_valid;
  logic        dump_ready;
  logic [7:0]  dump_addr;
  logic [7:0]  dump_data;
  logic        finished;
  logic        timeout_err;
  logic [15:0] run_cycles;

  modport master (
    input  ld_valid, ld_addr, ld_data, go,
    input  mem_rdata, done, dump_ready,
    output ld_ready, mem_addr, mem_wdata, mem_we,
    output start, run_active,
    output dump_valid, dump_addr, dump_data,
    output finished, timeout_err, run_cycles
  );

  modport slave (
    output ld_valid, ld_addr, ld_data, go,
    output mem_rdata, done, dump_ready,
    input  ld_ready, mem_addr, mem_wdata, mem_we,
    input  start, run_active,
    input  dump_valid, dump_addr, dump_data,
    input  finished, timeout_err, run_cycles
  );
endinterface

// File: rtl/run_host_ctrl.sv
// Host controller: preload data memory, pulse start,
// time the run, then stream a result window back out.
module run_host_ctrl #(
  parameter int          START_CYCLES = 2,
  parameter logic [7:0]  DUMP_BASE    = 8'd0,
  parameter logic [7:0]  DUMP_LEN     = 8'd16,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       reset_n,
  run_host_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DPREP = 3'd3;
  localparam logic [2:0] S_DOUT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam int SC = (START_CYCLES < 1) ? 1 : START_CYCLES;
  localparam int CW = $clog2(SC + 1);
  localparam logic [CW-1:0] SC_LAST = CW'(SC - 1);

  // A zero length encodes a full 256-byte window
  localparam logic [8:0] LEN9 =
    (DUMP_LEN == 8'd0) ? 9'd256 : {1'b0, DUMP_LEN};
  localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

  logic [2:0]    state;
  logic [CW-1:0] start_cnt;
  logic [7:0]    ptr;
  logic [8:0]    count;
  logic [15:0]   run_cycles;
  logic          dump_valid;
  logic [7:0]    dump_addr;
  logic [7:0]    dump_data;
  logic          finished;
  logic          timeout_err;
  logic          host_port;

  assign host_port = (state == S_IDLE) ||
                     (state == S_FIN);

  assign bus.ld_ready   = host_port;
  assign bus.mem_we     = host_port & bus.ld_valid;
  assign bus.mem_addr   = host_port ? bus.ld_addr : ptr;
  assign bus.mem_wdata  = bus.ld_data;
  assign bus.start      = (state == S_START);
  assign bus.run_active = (state == S_START) ||
                          (state == S_RUN);

  assign bus.dump_valid  = dump_valid;
  assign bus.dump_addr   = dump_addr;
  assign bus.dump_data   = dump_data;
  assign bus.finished    = finished;
  assign bus.timeout_err = timeout_err;
  assign bus.run_cycles  = run_cycles;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      start_cnt   <= '0;
      ptr         <= 8'd0;
      count       <= 9'd0;
      run_cycles  <= 16'd0;
      dump_valid  <= 1'b0;
      dump_addr   <= 8'd0;
      dump_data   <= 8'd0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_FIN: begin
          if (bus.go) begin
            state       <= S_START;
            start_cnt   <= '0;
            finished    <= 1'b0;
            timeout_err <= 1'b0;
            run_cycles  <= 16'd0;
          end
        end
        S_START: begin
          if (start_cnt == SC_LAST)
            state <= S_RUN;
          else
            start_cnt <= start_cnt + 1'b1;
        end
        S_RUN: begin
          if (run_cycles != 16'hFFFF)
            run_cycles <= run_cycles + 16'd1;
          // done wins over a timeout in the same cycle
          if (bus.done) begin
            state <= S_DPREP;
            ptr   <= DUMP_BASE;
            count <= LEN9;
          end else if (run_cycles == TO_LAST) begin
            state       <= S_FIN;
            timeout_err <= 1'b1;
            finished    <= 1'b1;
          end
        end
        S_DPREP: begin
          dump_data  <= bus.mem_rdata;
          dump_addr  <= ptr;
          dump_valid <= 1'b1;
          state      <= S_DOUT;
        end
        S_DOUT: begin
          if (bus.dump_ready) begin
            dump_valid <= 1'b0;
            ptr        <= ptr + 8'd1;
            count      <= count - 9'd1;
            if (count == 9'd1) begin
              state    <= S_FIN;
              finished <= 1'b1;
            end else begin
              state <= S_DPREP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_host_ctrl.sv
// Randomized bench for run_host_ctrl against a
// transaction-level model of loads, runs and dumps.
module tb_run_host_ctrl;

  localparam int          SC   = 2;
  localparam logic [7:0]  BASE = 8'hFE;
  localparam int          LEN  = 4;
  localparam int          TO   = 20;

  logic CLK = 1'b0;
  logic reset_n;

  always #5 CLK = ~CLK;

  run_host_if bus ();

  run_host_ctrl #(
    .START_CYCLES(SC),
    .DUMP_BASE(BASE),
    .DUMP_LEN(8'(LEN)),
    .TIMEOUT(16'(TO))
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [7:0] tb_mem [256] = '{default: 8'h00};
  logic [7:0] shadow [256] = '{default: 8'h00};

  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  always @(posedge CLK)
    if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;

  int n_chk = 0;
  int n_fail = 0;
  logic        exp_fin;
  logic        exp_to;
  logic [15:0] exp_rc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, ".start"}, 32'(bus.start), 0);
    chk({ph, ".mem_we"}, 32'(bus.mem_we), 0);
    chk({ph, ".dvalid"}, 32'(bus.dump_valid), 0);
    chk({ph, ".ractive"}, 32'(bus.run_active), 0);
    chk({ph, ".fin"}, 32'(bus.finished), 0);
    chk({ph, ".to"}, 32'(bus.timeout_err), 0);
    chk({ph, ".rc"}, 32'(bus.run_cycles), 0);
    chk({ph, ".daddr"}, 32'(bus.dump_addr), 0);
    chk({ph, ".ddata"}, 32'(bus.dump_data), 0);
    chk({ph, ".ldrdy"}, 32'(bus.ld_ready), 1);
  endtask

  task automatic quiet();
    bus.ld_valid   = 1'b0;
    bus.go         = 1'b0;
    bus.done       = 1'b0;
    bus.dump_ready = 1'b0;
  endtask

  task automatic pulse_reset(input string ph);
    quiet();
    reset_n = 1'b0;
    #1 chk_reset(ph);
    @(posedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    exp_fin = 1'b0;
    exp_to  = 1'b0;
    exp_rc  = 16'd0;
    @(posedge CLK);
  endtask

  task automatic load(input logic [7:0] a,
                      input logic [7:0] d);
    @(negedge CLK);
    bus.go       = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    #1;
    chk("ld.ready", 32'(bus.ld_ready), 1);
    chk("ld.we", 32'(bus.mem_we), 1);
    chk("ld.addr", 32'(bus.mem_addr), 32'(a));
    chk("ld.wdata", 32'(bus.mem_wdata), 32'(d));
    shadow[a] = d;
    @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    quiet();
    #1 chk("idle.we", 32'(bus.mem_we), 0);
    @(posedge CLK);
  endtask

  // abort: 0 none, 1 reset mid-RUN, 2 reset mid-DOUT
  task automatic run_once(input int done_at,
                          input int abort);
    int k;
    logic [7:0] p;
    @(negedge CLK);
    bus.go       = 1'b1;
    bus.ld_valid = 1'($urandom);
    bus.ld_addr  = 8'($urandom);
    bus.ld_data  = 8'($urandom);
    #1 chk("go.we", 32'(bus.mem_we), 32'(bus.ld_valid));
    if (bus.ld_valid) shadow[bus.ld_addr] = bus.ld_data;
    @(posedge CLK);
    exp_fin = 1'b0;
    exp_to  = 1'b0;
    exp_rc  = 16'd0;
    for (int i = 0; i < SC; i++) begin
      @(negedge CLK);
      bus.go       = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 8'($urandom);
      bus.done     = 1'($urandom);
      #1;
      chk("st.start", 32'(bus.start), 1);
      chk("st.ract", 32'(bus.run_active), 1);
      chk("st.ldrdy", 32'(bus.ld_ready), 0);
      chk("st.we", 32'(bus.mem_we), 0);
      chk("st.fin", 32'(bus.finished), 0);
      @(posedge CLK);
    end
    k = 0;
    forever begin
      @(negedge CLK);
      bus.ld_valid = 1'($urandom);
      bus.done     = (k == done_at);
      #1;
      chk("run.start", 32'(bus.start), 0);
      chk("run.ract", 32'(bus.run_active), 1);
      chk("run.we", 32'(bus.mem_we), 0);
      chk("run.rc", 32'(bus.run_cycles), 32'(k));
      if (abort == 1 && k == 3) begin
        pulse_reset("rst_run");
        return;
      end
      @(posedge CLK);
      if (k == done_at || k == TO - 1) break;
      k++;
    end
    exp_rc = 16'(k + 1);
    if (k != done_at) begin
      exp_to  = 1'b1;
      exp_fin = 1'b1;
    end else begin
      p = BASE;
      for (int b = 0; b < LEN; b++) begin
        int st;
        @(negedge CLK);
        bus.done     = 1'b0;
        bus.ld_valid = 1'($urandom);
        #1;
        chk("dp.ract", 32'(bus.run_active), 0);
        chk("dp.dvalid", 32'(bus.dump_valid), 0);
        chk("dp.maddr", 32'(bus.mem_addr), 32'(p));
        chk("dp.we", 32'(bus.mem_we), 0);
        chk("dp.rc", 32'(bus.run_cycles), 32'(exp_rc));
        @(posedge CLK);
        st = (b == 1) ? 3 : int'($urandom_range(0, 2));
        for (int s = 0; s <= st; s++) begin
          @(negedge CLK);
          bus.ld_valid   = 1'b0;
          bus.dump_ready = (s == st);
          #1;
          chk("do.dvalid", 32'(bus.dump_valid), 1);
          chk("do.daddr", 32'(bus.dump_addr), 32'(p));
          chk("do.ddata", 32'(bus.dump_data),
              32'(shadow[p]));
          if (abort == 2 && b == 1 && s == 1) begin
            pulse_reset("rst_dout");
            return;
          end
          @(posedge CLK);
        end
        p = p + 8'd1;
      end
      exp_fin = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      bus.dump_ready = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.done       = 1'($urandom);
      #1;
      chk("fin.fin", 32'(bus.finished), 32'(exp_fin));
      chk("fin.to", 32'(bus.timeout_err), 32'(exp_to));
      chk("fin.rc", 32'(bus.run_cycles), 32'(exp_rc));
      chk("fin.dvalid", 32'(bus.dump_valid), 0);
      chk("fin.ract", 32'(bus.run_active), 0);
      chk("fin.ldrdy", 32'(bus.ld_ready), 1);
      @(posedge CLK);
    end
    @(negedge CLK);
    bus.done = 1'b0;
    @(posedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    bus.ld_addr = 8'd0;
    bus.ld_data = 8'd0;
    quiet();
    repeat (2) @(negedge CLK);
    #1 chk_reset("por");
    @(negedge CLK);
    reset_n = 1'b1;
    @(posedge CLK);

    load(8'h00, 8'h05);
    load(8'h01, 8'h07);
    load(8'h02, 8'h00);
    idle();
    load(8'hFE, 8'($urandom));
    load(8'hFF, 8'($urandom));
    idle();

    run_once(9, 0);
    load(8'h01, 8'($urandom));
    load(8'h00, 8'($urandom));
    run_once(1000, 0);
    run_once(19, 0);
    run_once(0, 0);

    run_once(8, 1);
    run_once(5, 0);
    run_once(4, 2);
    run_once(7, 0);

    for (int r = 0; r < 6; r++) begin
      int nl = int'($urandom_range(0, 3));
      for (int j = 0; j < nl; j++)
        load(BASE + 8'($urandom_range(0, 3)),
             8'($urandom));
      idle();
      run_once(int'($urandom_range(0, 25)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
